uart_time_rx: RTL and testbench

Serial time-set receiver for the stopwatch/watch top. It accepts 8N1 UART bytes on a single pin and parses ASCII set-time commands of the form 'T' HH MM SS CC CR. Each valid command produces the packed 24-bit time word used by the watch datapath and the display mux, plus a one-cycle load strobe. It is the inbound counterpart of the time bitstream the watch produces: it writes time into the watch counters instead of reading it out.

---
 rtl/uart_time_pkg.sv | 28 ++
 rtl/uart_rx_core.sv | 135 +++++++++++++
 rtl/uart_time_rx.sv | 135 +++++++++++++
 tb/tb_uart_time_rx.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_time_pkg.sv
// Shared constants, state types and field helpers for the UART time-set receiver.
package uart_time_pkg;

    localparam logic [7:0] ASCII_T  = 8'h54;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_0  = 8'h30;

    // Packed time word layout: hour | min | sec | csec
    localparam int HOUR_LSB = 19;
    localparam int HOUR_W   = 5;
    localparam int MIN_LSB  = 13;
    localparam int MIN_W    = 6;
    localparam int SEC_LSB  = 7;
    localparam int SEC_W    = 6;
    localparam int CSEC_LSB = 0;
    localparam int CSEC_W   = 7;

    localparam logic [23:0] RESET_TIME = 24'h600000;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {P_IDLE, P_DIGIT, P_END} parse_state_t;

    // Two BCD digits to a binary value; kept at 7 bits so range checks see the true value.
    function automatic logic [6:0] two_digit(input logic [3:0] tens, input logic [3:0] ones);
        return ({3'b000, tens} * 7'd10) + {3'b000, ones};
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchronizer, 16x oversample tick and bit-level FSM.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronized line
// START | counting to mid start bit; a high line there is a glitch
// DATA  | sampling 8 data bits LSB first, one every 16 ticks
// STOP  | sampling the stop bit; high -> byte valid, low -> framing error
module uart_rx_core
    import uart_time_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int DIV   = CLK_FREQ / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic             rx_meta, rx_sync, rx_prev;
    logic             fall;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       phase;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    rx_state_t        state, state_nxt;
    logic             phase_clr, sample_bit, valid_set, ferr_set;

    // Two-flop synchronizer plus one history flop for edge detection; all idle high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall = rx_prev & ~rx_sync;

    // Free-running oversample divider; one tick each time the down-counter hits zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div_cnt <= DIV_W'(DIV - 1);
        else if (tick)
            div_cnt <= DIV_W'(DIV - 1);
        else
            div_cnt <= div_cnt - DIV_W'(1);
    end

    assign tick = (div_cnt == '0);

    // Bit FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Bit FSM next state and datapath controls.
    always_comb begin
        state_nxt  = state;
        phase_clr  = 1'b0;
        sample_bit = 1'b0;
        valid_set  = 1'b0;
        ferr_set   = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                    phase_clr = 1'b1;
                end
            end
            START: begin
                if (tick && phase == 4'd7) begin
                    phase_clr = 1'b1;
                    state_nxt = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick && phase == 4'd15) begin
                    sample_bit = 1'b1;
                    if (bit_cnt == 3'd7)
                        state_nxt = STOP;
                end
            end
            STOP: begin
                if (tick && phase == 4'd15) begin
                    state_nxt = IDLE;
                    valid_set = rx_sync;
                    ferr_set  = ~rx_sync;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Tick phase, bit counter, shift register and registered strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase     <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (phase_clr) begin
                phase   <= '0;
                bit_cnt <= '0;
            end else if (tick) begin
                phase <= phase + 4'd1;
            end
            if (sample_bit) begin
                shift   <= {rx_sync, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (valid_set)
                rx_data <= shift;
            rx_valid  <= valid_set;
            frame_err <= ferr_set;
        end
    end

endmodule

// File: rtl/uart_time_rx.sv
// Serial time-set receiver: parses 'T' HHMMSSCC CR commands into the packed watch time word.
//
// state   | meaning
// P_IDLE  | no command open; non-'T' bytes are ignored
// P_DIGIT | collecting the eight time digits
// P_END   | all digits in; waiting for CR to validate and load
module uart_time_rx
    import uart_time_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_rx,
    output logic [23:0] o_time,
    output logic        o_load,
    output logic [7:0]  o_rx_data,
    output logic        o_rx_valid,
    output logic        o_frame_err,
    output logic        o_cmd_err
);

    logic [7:0]   rx_data;
    logic         rx_valid, frame_err;
    parse_state_t p_state, p_state_nxt;
    logic [2:0]   dig_cnt;
    logic [3:0]   digits [8];
    logic [6:0]   hour_val, min_val, sec_val, csec_val;
    logic         in_range, is_digit;
    logic [23:0]  time_new;
    logic         cnt_clr, dig_we, load_set, err_set;

    uart_rx_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .rx        (i_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
    );

    assign o_rx_data   = rx_data;
    assign o_rx_valid  = rx_valid;
    assign o_frame_err = frame_err;

    assign is_digit = (rx_data >= ASCII_0) && (rx_data <= ASCII_0 + 8'd9);

    // Field composition and range check at full 7-bit width before truncation.
    always_comb begin
        hour_val = two_digit(digits[0], digits[1]);
        min_val  = two_digit(digits[2], digits[3]);
        sec_val  = two_digit(digits[4], digits[5]);
        csec_val = two_digit(digits[6], digits[7]);
        in_range = (hour_val <= 7'd23) && (min_val <= 7'd59) && (sec_val <= 7'd59);
        time_new = '0;
        time_new[HOUR_LSB +: HOUR_W] = hour_val[HOUR_W-1:0];
        time_new[MIN_LSB  +: MIN_W]  = min_val[MIN_W-1:0];
        time_new[SEC_LSB  +: SEC_W]  = sec_val[SEC_W-1:0];
        time_new[CSEC_LSB +: CSEC_W] = csec_val;
    end

    // Parser state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            p_state <= P_IDLE;
        else
            p_state <= p_state_nxt;
    end

    // Parser next state; 'T' restarts from anywhere, a framing error aborts the command.
    always_comb begin
        p_state_nxt = p_state;
        cnt_clr     = 1'b0;
        dig_we      = 1'b0;
        load_set    = 1'b0;
        err_set     = 1'b0;
        if (rx_valid) begin
            if (rx_data == ASCII_T) begin
                p_state_nxt = P_DIGIT;
                cnt_clr     = 1'b1;
            end else begin
                case (p_state)
                    P_DIGIT: begin
                        if (is_digit) begin
                            dig_we = 1'b1;
                            if (dig_cnt == 3'd7)
                                p_state_nxt = P_END;
                        end else begin
                            err_set     = 1'b1;
                            p_state_nxt = P_IDLE;
                        end
                    end
                    P_END: begin
                        p_state_nxt = P_IDLE;
                        if (rx_data == ASCII_CR && in_range)
                            load_set = 1'b1;
                        else
                            err_set = 1'b1;
                    end
                    default: p_state_nxt = P_IDLE;
                endcase
            end
        end
        if (frame_err)
            p_state_nxt = P_IDLE;
    end

    // Digit storage, time register and command strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig_cnt   <= '0;
            for (int i = 0; i < 8; i++)
                digits[i] <= '0;
            o_time    <= RESET_TIME;
            o_load    <= 1'b0;
            o_cmd_err <= 1'b0;
        end else begin
            if (cnt_clr)
                dig_cnt <= '0;
            else if (dig_we) begin
                digits[dig_cnt] <= rx_data[3:0];
                dig_cnt         <= dig_cnt + 3'd1;
            end
            if (load_set)
                o_time <= time_new;
            o_load    <= load_set;
            o_cmd_err <= err_set;
        end
    end

endmodule

// File: tb/tb_uart_time_rx.sv
// Scoreboard bench for uart_time_rx: stimulus pushes expectations, a monitor pops them on DUT strobes.
module tb_uart_time_rx;

    localparam int CLK_FREQ = 320_000;
    localparam int BAUD     = 10_000;
    localparam int DIV_TB   = CLK_FREQ / (BAUD * 16);
    localparam int BIT_CLKS = 16 * DIV_TB;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        bit          is_load;
        logic [23:0] t;
    } evt_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_rx = 1'b1;
    logic [23:0] o_time;
    logic        o_load, o_rx_valid, o_frame_err, o_cmd_err;
    logic [7:0]  o_rx_data;

    int errors = 0;
    int checks = 0;

    logic [7:0]  exp_rx [$];
    evt_t        exp_evt [$];
    int          n_ferr = 0;

    bit          m_active;
    int          m_digits [$];
    logic [23:0] m_time;

    uart_time_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_rx        (i_rx),
        .o_time      (o_time),
        .o_load      (o_load),
        .o_rx_data   (o_rx_data),
        .o_rx_valid  (o_rx_valid),
        .o_frame_err (o_frame_err),
        .o_cmd_err   (o_cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    // Reference model: tracks the command text since the last 'T' and decides at CR.
    task automatic model_byte(input logic [7:0] b);
        int hh, mm, ss, cc;
        evt_t e;
        if (b == 8'h54) begin
            m_active = 1;
            m_digits.delete();
        end else if (m_active) begin
            if (m_digits.size() < 8) begin
                if (b >= 8'h30 && b <= 8'h39) begin
                    m_digits.push_back(int'(b) - 48);
                end else begin
                    m_active = 0;
                    e.is_load = 0; e.t = m_time; exp_evt.push_back(e);
                end
            end else begin
                m_active = 0;
                hh = m_digits[0] * 10 + m_digits[1];
                mm = m_digits[2] * 10 + m_digits[3];
                ss = m_digits[4] * 10 + m_digits[5];
                cc = m_digits[6] * 10 + m_digits[7];
                if (b == 8'h0D && hh < 24 && mm < 60 && ss < 60) begin
                    m_time = 24'(hh * 524288 + mm * 8192 + ss * 128 + cc);
                    e.is_load = 1;
                end else begin
                    e.is_load = 0;
                end
                e.t = m_time;
                exp_evt.push_back(e);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        if (stop_ok) begin
            exp_rx.push_back(b);
            model_byte(b);
        end else begin
            n_ferr++;
            m_active = 0;
        end
        @(negedge clk);
        i_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        i_rx = stop_ok;
        repeat (BIT_CLKS) @(negedge clk);
        i_rx = 1'b1;
        if (!stop_ok) repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_seq(input byte_q_t q, input int max_gap);
        foreach (q[i]) begin
            send_byte(q[i], 1'b1);
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        i_rx = 1'b1;
        reset = 1'b1;
        exp_rx.delete();
        exp_evt.delete();
        n_ferr = 0;
        m_active = 0;
        m_digits.delete();
        m_time = 24'h600000;
        repeat (3) @(negedge clk);
        chk("reset_time", o_time, 24'h600000);
        chk("reset_load", o_load, 0);
        chk("reset_rx_valid", o_rx_valid, 0);
        chk("reset_frame_err", o_frame_err, 0);
        chk("reset_cmd_err", o_cmd_err, 0);
        chk("reset_rx_data", o_rx_data, 0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_rx.size() + exp_evt.size() + n_ferr) != 0 && n < 4 * BIT_CLKS) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk(name, exp_rx.size() + exp_evt.size() + n_ferr, 0);
    endtask

    function automatic byte_q_t cmd(input int hh, input int mm, input int ss, input int cc);
        byte_q_t q;
        q = '{8'h54,
              8'(48 + hh / 10), 8'(48 + hh % 10), 8'(48 + mm / 10), 8'(48 + mm % 10),
              8'(48 + ss / 10), 8'(48 + ss % 10), 8'(48 + cc / 10), 8'(48 + cc % 10), 8'h0D};
        return q;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT strobes.
    initial begin
        logic [7:0] eb;
        evt_t       e;
        bit         prev_valid;
        prev_valid = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 0;
            end else begin
                if (o_rx_valid) begin
                    if (exp_rx.size() == 0) flag("rx_valid_unexpected");
                    else begin
                        eb = exp_rx.pop_front();
                        chk("rx_data", o_rx_data, eb);
                    end
                end
                if (o_frame_err) begin
                    if (n_ferr == 0) flag("frame_err_unexpected");
                    else n_ferr--;
                end
                if (o_load || o_cmd_err) begin
                    chk("strobe_excl", o_load & o_cmd_err, 0);
                    chk("strobe_latency", prev_valid, 1);
                    if (exp_evt.size() == 0) flag(o_load ? "load_unexpected" : "cmd_err_unexpected");
                    else begin
                        e = exp_evt.pop_front();
                        chk(o_load ? "evt_is_load" : "evt_is_cmd_err", o_load, e.is_load);
                        chk(o_load ? "load_time" : "cmd_err_time", o_time, e.t);
                    end
                end
                prev_valid = o_rx_valid;
            end
        end
    end

    initial begin
        repeat (95_000) @(posedge clk);
        $display("FAIL watchdog: cycle limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q_t q;
        int      sel, n, hh, mm, ss, cc;
        logic [7:0] b;

        do_reset();

        send_seq(cmd(13, 45, 7, 25), 0);
        drain("drain_valid_cmd");
        chk("time_134507", o_time, 24'h6DA399);

        send_seq(cmd(24, 0, 0, 0), 0);
        drain("drain_hour24");
        chk("time_after_hour24", o_time, 24'h6DA399);

        q = '{8'h54, 8'h31, 8'h32, 8'h33, 8'h41};
        send_seq(q, 0);
        send_seq(cmd(0, 0, 0, 0), 0);
        drain("drain_bad_digit");
        chk("time_zero", o_time, 24'h000000);

        q = '{8'h54, 8'h31, 8'h32};
        send_seq(q, 0);
        send_byte(8'h33, 1'b0);
        q = '{8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0D};
        send_seq(q, 0);
        send_seq(cmd(23, 59, 59, 99), 0);
        drain("drain_frame_err");
        chk("time_235959", o_time, 24'hBF7DE3);

        @(negedge clk);
        i_rx = 1'b0;
        repeat (BIT_CLKS * 9 / 32) @(negedge clk);
        i_rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        send_byte(8'hA5, 1'b1);
        drain("drain_glitch");
        chk("rx_data_a5", o_rx_data, 8'hA5);

        q = '{8'h54, 8'h31, 8'h32};
        send_seq(q, 0);
        @(negedge clk);
        i_rx = 1'b0;
        repeat (BIT_CLKS * 3) @(negedge clk);
        i_rx = 1'b0;
        do_reset();
        q = '{8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h0D};
        send_seq(q, 0);
        drain("drain_after_reset");
        chk("time_after_reset", o_time, 24'h600000);

        for (int k = 0; k < 8; k++) begin
            sel = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) send_byte(8'($urandom_range(0, 255)), 1'b1);
            case (sel)
                0: q = cmd($urandom_range(0, 23), $urandom_range(0, 59),
                           $urandom_range(0, 59), $urandom_range(0, 99));
                1: q = cmd($urandom_range(0, 99), $urandom_range(0, 99),
                           $urandom_range(0, 99), $urandom_range(0, 99));
                2: begin
                    q = '{8'h54};
                    n = $urandom_range(0, 7);
                    for (int i = 0; i < n; i++) q.push_back(8'(48 + $urandom_range(0, 9)));
                    do b = 8'($urandom_range(0, 255));
                    while ((b >= 8'h30 && b <= 8'h39) || b == 8'h54);
                    q.push_back(b);
                end
                default: begin
                    hh = $urandom_range(0, 23); mm = $urandom_range(0, 59);
                    ss = $urandom_range(0, 59); cc = $urandom_range(0, 99);
                    q = cmd(hh, mm, ss, cc);
                    do b = 8'($urandom_range(0, 255));
                    while (b == 8'h0D || b == 8'h54);
                    q[9] = b;
                end
            endcase
            send_seq(q, BIT_CLKS);
        end
        drain("drain_random");
        chk("time_final", o_time, m_time);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
